// File: rtl/kgp_diff_pkg.sv
// Shared definitions for the KGP-RISC diff engine controller:
// FSM encoding, requester IDs and default geometry.
package kgp_diff_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_STEP  = 4;
    localparam int DEF_IDX_W = 6;

endpackage

// File: rtl/diff_chunk_pe.sv
// Lowest-set-bit priority encoder over one STEP-bit chunk of the xor word.
module diff_chunk_pe #(
    parameter int STEP  = 4,
    parameter int POS_W = (STEP > 1) ? $clog2(STEP) : 1
) (
    input  logic [STEP-1:0]  bits,
    output logic             found,
    output logic [POS_W-1:0] pos
);

    always_comb begin
        found = |bits;
        pos   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = STEP - 1; i >= 0; i--) begin
            if (bits[i]) begin
                pos = POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/diff_seq_ctrl.sv
// Round-robin shared iterative diff engine: reports the lowest bit index
// where rs and rt differ (WIDTH when equal), scanning STEP bits per cycle.
module diff_seq_ctrl
    import kgp_diff_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_rs,
    input  logic [WIDTH-1:0] req0_rt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_rs,
    input  logic [WIDTH-1:0] req1_rt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_out
);

    localparam int POS_W = (STEP > 1) ? $clog2(STEP) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_out_q, resp_out_d;

    logic             grant0, grant1;
    logic             pe_found;
    logic [POS_W-1:0] pe_pos;

    // On contention the requester that did not win last time is granted.
    assign grant0 = req0_valid && (!req1_valid || (last_grant_q == REQ_DBG));
    assign grant1 = req1_valid && (!req0_valid || (last_grant_q == REQ_ALU));

    diff_chunk_pe #(
        .STEP  (STEP),
        .POS_W (POS_W)
    ) u_pe (
        .bits  (x_q[STEP-1:0]),
        .found (pe_found),
        .pos   (pe_pos)
    );

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        idx_d        = idx_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_out_d   = resp_out_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            S_IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0) begin
                    x_d          = req0_rs ^ req0_rt;
                    idx_d        = '0;
                    id_d         = REQ_ALU;
                    last_grant_d = REQ_ALU;
                    state_d      = S_SCAN;
                end else if (grant1) begin
                    x_d          = req1_rs ^ req1_rt;
                    idx_d        = '0;
                    id_d         = REQ_DBG;
                    last_grant_d = REQ_DBG;
                    state_d      = S_SCAN;
                end
            end

            S_SCAN: begin
                if (x_q == '0) begin
                    resp_out_d   = WIDTH'(WIDTH);
                    resp_id_d    = id_q;
                    resp_valid_d = 1'b1;
                    state_d      = S_DONE;
                end else if (pe_found) begin
                    resp_out_d   = WIDTH'(idx_q) + WIDTH'(pe_pos);
                    resp_id_d    = id_q;
                    resp_valid_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    // x is nonzero here, so idx stops short of WIDTH.
                    x_d   = x_q >> STEP;
                    idx_d = idx_q + IDX_W'(STEP);
                end
            end

            S_DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            idx_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            idx_q        <= idx_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_out_q   <= resp_out_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_out   = resp_out_q;

endmodule
